// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit bridging the EX stage to a single-beat ack-based memory bus
//
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   mem_en           : EX memory request, held until done or an error pulse
//   mem_write        : 1 = store, 0 = load
//   mem_size         : 0 byte, 1 half, 2/3 word
//   mem_sign_ext     : sign-extend loads when 1
//   mem_addr         : effective byte address
//   mem_wdata        : right-justified store data
//   flush            : pipeline flush, cancels the reported result
//   bus_*            : word-aligned bus request with byte enables, bus_ack/bus_rdata response
//   load_data        : extended load result, held until the next response
//   done             : one-cycle success pulse
//   stall_req        : holds the pipeline while a request is accepted or on the bus
//   addr_err_load/store, bus_err : one-cycle error pulses
//   bad_vaddr        : faulting address of the last misaligned access

module mem_access_unit #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign_ext,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall_req,
  output logic        addr_err_load,
  output logic        addr_err_store,
  output logic        bus_err,
  output logic [31:0] bad_vaddr
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       op_size;
  logic             op_sign;
  logic [1:0]       op_lane;
  logic             op_write;

  // Result kind chosen on entry to RESP; the pulse itself is gated by flush
  // in the RESP cycle so a late flush can still cancel it.
  logic             rsp_done;
  logic             rsp_ael;
  logic             rsp_aes;
  logic             rsp_berr;

  logic             is_byte;
  logic             is_half;
  logic             misaligned;
  logic [3:0]       sel_nxt;
  logic [31:0]      wdata_nxt;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      rdata_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;

  assign is_byte    = (mem_size == 2'd0);
  assign is_half    = (mem_size == 2'd1);
  assign misaligned = (is_half && mem_addr[0]) ||
                      (!is_byte && !is_half && (mem_addr[1:0] != 2'b00));

  // Lane steering for the request; size 3 falls through to word.
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = mem_wdata;
    if (is_byte) begin
      sel_nxt   = 4'b0001 << mem_addr[1:0];
      wdata_nxt = {4{mem_wdata[7:0]}};
    end else if (is_half) begin
      sel_nxt   = 4'b0011 << mem_addr[1:0];
      wdata_nxt = {2{mem_wdata[15:0]}};
    end
  end

  // Little-endian lane extraction from the returned word.
  always_comb begin
    byte_v = bus_rdata[7:0];
    case (op_lane)
      2'd0:    byte_v = bus_rdata[7:0];
      2'd1:    byte_v = bus_rdata[15:8];
      2'd2:    byte_v = bus_rdata[23:16];
      default: byte_v = bus_rdata[31:24];
    endcase
    half_v = op_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_size)
      2'd0:    rdata_ext = {{24{op_sign & byte_v[7]}}, byte_v};
      2'd1:    rdata_ext = {{16{op_sign & half_v[15]}}, half_v};
      default: rdata_ext = bus_rdata;
    endcase
  end

  // Saturating wait counter; timeout fires on the cycle that would make
  // BUS_TIMEOUT unacknowledged cycles.
  assign cnt_inc = (wait_cnt == CNT_W'(BUS_TIMEOUT)) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(BUS_TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      op_size   <= 2'd0;
      op_sign   <= 1'b0;
      op_lane   <= 2'd0;
      op_write  <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_ael   <= 1'b0;
      rsp_aes   <= 1'b0;
      rsp_berr  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      load_data <= 32'd0;
      bad_vaddr <= 32'd0;
    end else begin
      rsp_done <= 1'b0;
      rsp_ael  <= 1'b0;
      rsp_aes  <= 1'b0;
      rsp_berr <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_en && !flush) begin
            op_size  <= mem_size;
            op_sign  <= mem_sign_ext;
            op_lane  <= mem_addr[1:0];
            op_write <= mem_write;
            if (misaligned) begin
              bad_vaddr <= mem_addr;
              rsp_ael   <= !mem_write;
              rsp_aes   <= mem_write;
              state     <= RESP;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_sel   <= sel_nxt;
              bus_addr  <= {mem_addr[31:2], 2'b00};
              bus_wdata <= wdata_nxt;
              wait_cnt  <= '0;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              load_data <= op_write ? 32'd0 : rdata_ext;
              rsp_done  <= 1'b1;
              state     <= RESP;
            end
          end else if (timeout) begin
            bus_req <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              rsp_berr <= 1'b1;
              state    <= RESP;
            end
          end else begin
            wait_cnt <= cnt_inc;
            // The bus cycle cannot be retracted; finish it silently.
            if (flush) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus_ack || timeout) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign done           = (state == RESP) && rsp_done && !flush;
  assign addr_err_load  = (state == RESP) && rsp_ael  && !flush;
  assign addr_err_store = (state == RESP) && rsp_aes  && !flush;
  assign bus_err        = (state == RESP) && rsp_berr && !flush;

  // Gated by rst so a request held during reset does not stall the pipeline.
  assign stall_req = rst && ((state == BUS) || ((state == IDLE) && mem_en && !flush));

endmodule
